// File: rtl/mesi_isc_broad_arb_pkg.sv
// Shared types and constants for the broadcast-request arbiter and its picker.
package mesi_isc_broad_arb_pkg;

    localparam int CPU_NUM      = 4;
    localparam int CPU_ID_WIDTH = 2;

    localparam int DEF_ADDR_WIDTH       = 32;
    localparam int DEF_BROAD_TYPE_WIDTH = 2;
    localparam int DEF_BROAD_ID_WIDTH   = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } broad_state_e;

    // Registered request record at the default widths, for consumers of the FIFO payload.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]       addr;
        logic [DEF_BROAD_TYPE_WIDTH-1:0] btype;
        logic [CPU_ID_WIDTH-1:0]         cpu_id;
        logic [DEF_BROAD_ID_WIDTH-1:0]   id;
    } broad_req_t;

endpackage

// File: rtl/mesi_isc_rr_pick.sv
// Combinational 4-way rotate-priority picker: first valid bit at or after ptr, wrapping 3->0.
module mesi_isc_rr_pick
    import mesi_isc_broad_arb_pkg::*;
(
    input  logic [CPU_NUM-1:0]      valid,
    input  logic [CPU_ID_WIDTH-1:0] ptr,
    output logic [CPU_NUM-1:0]      grant,
    output logic [CPU_ID_WIDTH-1:0] idx
);

    logic [CPU_NUM-1:0]      rot;
    logic [CPU_ID_WIDTH-1:0] offset;

    // rot[k] is the valid bit of the CPU k positions past the pointer; the add wraps naturally.
    generate
        for (genvar gi = 0; gi < CPU_NUM; gi++) begin : g_rot
            assign rot[gi] = valid[ptr + CPU_ID_WIDTH'(gi)];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = CPU_NUM - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = k[CPU_ID_WIDTH-1:0];
            end
        end
        idx   = ptr + offset;
        grant = '0;
        if (|valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mesi_isc_broad_arb.sv
// Broadcast FIFO write arbiter: round-robin over four CPU request ports, one write per two cycles.
// Define MESI_ISC_BROAD_ARB_FIXED_PRIO_EN for fixed priority (CPU0 highest) instead of round robin.
module mesi_isc_broad_arb
    import mesi_isc_broad_arb_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int BROAD_TYPE_WIDTH = DEF_BROAD_TYPE_WIDTH,
    parameter int BROAD_ID_WIDTH   = DEF_BROAD_ID_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CPU_NUM-1:0]               req_valid_array_i,
    input  logic [CPU_NUM*ADDR_WIDTH-1:0]    req_addr_array_i,
    input  logic [CPU_NUM*BROAD_TYPE_WIDTH-1:0] req_type_array_i,
    output logic [CPU_NUM-1:0]               req_ack_array_o,
    input  logic                             fifo_status_full_i,
    output logic                             broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]            broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]      broad_type_o,
    output logic [CPU_ID_WIDTH-1:0]          broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]        broad_id_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [BROAD_TYPE_WIDTH-1:0] btype;
        logic [CPU_ID_WIDTH-1:0]     cpu_id;
        logic [BROAD_ID_WIDTH-1:0]   id;
    } req_rec_t;

    broad_state_e              state_reg;
    req_rec_t                  rec_reg;
    logic [BROAD_ID_WIDTH-1:0] id_cnt_reg;
    logic                      wr_reg;
    logic [CPU_NUM-1:0]        ack_reg;
    logic [CPU_ID_WIDTH-1:0]   rr_ptr;
    logic [CPU_NUM-1:0]        pick_grant;
    logic [CPU_ID_WIDTH-1:0]   pick_idx;

    logic [ADDR_WIDTH-1:0]       addr_arr [CPU_NUM];
    logic [BROAD_TYPE_WIDTH-1:0] type_arr [CPU_NUM];

    generate
        for (genvar gi = 0; gi < CPU_NUM; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_array_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign type_arr[gi] = req_type_array_i[gi*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
        end
    endgenerate

`ifdef MESI_ISC_BROAD_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [CPU_ID_WIDTH-1:0] rr_ptr_reg;

    // The pointer only moves on the WRITE cycle, so a full FIFO never rotates priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else if (state_reg == WRITE) begin
            rr_ptr_reg <= rec_reg.cpu_id + 1'b1;
        end
    end

    assign rr_ptr = rr_ptr_reg;
`endif

    mesi_isc_rr_pick u_pick (
        .valid (req_valid_array_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            rec_reg    <= '0;
            id_cnt_reg <= '0;
            wr_reg     <= 1'b0;
            ack_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if ((|req_valid_array_i) && !fifo_status_full_i) begin
                        rec_reg.addr   <= addr_arr[pick_idx];
                        rec_reg.btype  <= type_arr[pick_idx];
                        rec_reg.cpu_id <= pick_idx;
                        rec_reg.id     <= id_cnt_reg;
                        wr_reg         <= 1'b1;
                        ack_reg        <= pick_grant;
                        state_reg      <= WRITE;
                    end
                end
                WRITE: begin
                    // Full rising now does not cancel: the grant was made against a not-full flag.
                    wr_reg     <= 1'b0;
                    ack_reg    <= '0;
                    id_cnt_reg <= id_cnt_reg + 1'b1;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign broad_fifo_wr_o = wr_reg;
    assign req_ack_array_o = ack_reg;
    assign broad_addr_o    = rec_reg.addr;
    assign broad_type_o    = rec_reg.btype;
    assign broad_cpu_id_o  = rec_reg.cpu_id;
    assign broad_id_o      = rec_reg.id;

endmodule

// File: tb/tb_mesi_isc_broad_arb.sv
// Randomized bench for mesi_isc_broad_arb against a transaction-level arbitration model.
module tb_mesi_isc_broad_arb;

    localparam int AW = 32;
    localparam int TW = 2;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid_array_i;
    logic [4*AW-1:0] req_addr_array_i;
    logic [4*TW-1:0] req_type_array_i;
    logic [3:0]    req_ack_array_o;
    logic          fifo_status_full_i;
    logic          broad_fifo_wr_o;
    logic [AW-1:0] broad_addr_o;
    logic [TW-1:0] broad_type_o;
    logic [1:0]    broad_cpu_id_o;
    logic [IW-1:0] broad_id_o;

    mesi_isc_broad_arb #(
        .ADDR_WIDTH       (AW),
        .BROAD_TYPE_WIDTH (TW),
        .BROAD_ID_WIDTH   (IW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_array_i  (req_valid_array_i),
        .req_addr_array_i   (req_addr_array_i),
        .req_type_array_i   (req_type_array_i),
        .req_ack_array_o    (req_ack_array_o),
        .fifo_status_full_i (fifo_status_full_i),
        .broad_fifo_wr_o    (broad_fifo_wr_o),
        .broad_addr_o       (broad_addr_o),
        .broad_type_o       (broad_type_o),
        .broad_cpu_id_o     (broad_cpu_id_o),
        .broad_id_o         (broad_id_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester side: each CPU either has a pending request (held stable) or is idle.
    bit          pend [4];
    logic [AW-1:0] r_addr [4];
    logic [TW-1:0] r_type [4];

    // Expected FIFO-side view. The model tracks the last winner and the number of grants;
    // priority and ids are derived from those.
    bit          m_wr;
    logic [3:0]  m_ack;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_type;
    logic [1:0]  m_cpu;
    logic [IW-1:0] m_bid;
    int          n_grants;
    int          last_win;

    task automatic model_reset();
        m_wr = 0; m_ack = '0; m_addr = '0; m_type = '0; m_cpu = '0; m_bid = '0;
        n_grants = 0;
        last_win = -1;
    endtask

    // Applied at each rising edge with the inputs that were stable across it.
    task automatic model_step();
        int start, w;
        if (m_wr) begin
            // A write occupies a full cycle; nothing new is granted alongside it.
            m_wr  = 0;
            m_ack = '0;
        end else if (req_valid_array_i != 4'b0 && !fifo_status_full_i) begin
`ifdef MESI_ISC_BROAD_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = (last_win + 1) % 4;
`endif
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req_valid_array_i[(start + k) % 4]) w = (start + k) % 4;
            end
            m_wr     = 1;
            m_ack    = 4'b0001 << w;
            m_cpu    = 2'(w);
            m_addr   = r_addr[w];
            m_type   = r_type[w];
            m_bid    = IW'(n_grants % (1 << IW));
            n_grants = n_grants + 1;
            last_win = w;
            $display("write #%0d cpu=%0d id=%0d addr=0x%08h type=%0d", n_grants, w, m_bid, m_addr, m_type);
        end
    endtask

    task automatic check_outputs();
        check("wr",     32'(broad_fifo_wr_o), 32'(m_wr));
        check("ack",    32'(req_ack_array_o), 32'(m_ack));
        check("addr",   broad_addr_o,         m_addr);
        check("type",   32'(broad_type_o),    32'(m_type));
        check("cpu_id", 32'(broad_cpu_id_o),  32'(m_cpu));
        check("id",     32'(broad_id_o),      32'(m_bid));
    endtask

    task automatic drive(input int p_new, input int p_wd, input int p_full);
        for (int n = 0; n < 4; n++) begin
            if (m_ack[n]) begin
                pend[n] = 0;
            end else if (pend[n] && $urandom_range(0, 99) < p_wd) begin
                pend[n] = 0;
            end
            if (!pend[n] && $urandom_range(0, 99) < p_new) begin
                pend[n]   = 1;
                r_addr[n] = $urandom;
                r_type[n] = TW'($urandom_range(0, (1 << TW) - 1));
            end
        end
        for (int n = 0; n < 4; n++) begin
            req_valid_array_i[n]            = pend[n];
            req_addr_array_i[n*AW +: AW]    = r_addr[n];
            req_type_array_i[n*TW +: TW]    = r_type[n];
        end
        fifo_status_full_i = ($urandom_range(0, 99) < p_full);
    endtask

    task automatic run(input int cycles, input int p_new, input int p_wd, input int p_full,
                       input bit rst_mid);
        bit done_rst = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
            if (rst_mid && !done_rst && m_wr) begin
                // Asynchronous reset in the middle of a write: the write is lost.
                done_rst = 1;
                rst = 1'b0;
                #1;
                model_reset();
                check_outputs();
                $display("reset asserted during write at %0t", $time);
                @(negedge clk);
                rst = 1'b1;
            end else begin
                drive(p_new, p_wd, p_full);
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            pend[n] = 0; r_addr[n] = '0; r_type[n] = '0;
        end
        req_valid_array_i  = '0;
        req_addr_array_i   = '0;
        req_type_array_i   = '0;
        fifo_status_full_i = 1'b0;
        rst = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single request from CPU2 with a known payload.
        pend[2] = 1; r_addr[2] = 32'h100; r_type[2] = 2'd1;
        req_valid_array_i = 4'b0100;
        req_addr_array_i[2*AW +: AW] = 32'h100;
        req_type_array_i[2*TW +: TW] = 2'd1;
        run(6, 0, 0, 0, 0);

        // Everyone always requesting, FIFO never full: rotation and id wrap past 32 writes.
        run(140, 100, 0, 0, 0);

        // FIFO full for a stretch with only CPU1 requesting.
        for (int n = 0; n < 4; n++) pend[n] = 0;
        pend[1] = 1; r_addr[1] = 32'hCAFE_0001; r_type[1] = 2'd3;
        req_valid_array_i = 4'b0010;
        req_addr_array_i[1*AW +: AW] = r_addr[1];
        req_type_array_i[1*TW +: TW] = r_type[1];
        fifo_status_full_i = 1'b1;
        run(10, 0, 0, 100, 0);
        run(4, 0, 0, 0, 0);

        // Random traffic with full, withdrawals, and a reset landing on a write.
        run(600, 30, 3, 35, 0);
        run(300, 50, 2, 20, 1);
        run(300, 70, 5, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
